operand_fetch_ctrl: RTL and testbench

OPERAND_FETCH_CTRL -- requirements
Module: operand_fetch_ctrl

---
 rtl/operand_fetch_ctrl_if.sv | 31 +++
 rtl/operand_fetch_ctrl.sv | 107 ++++++++++
 tb/tb_operand_fetch_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_ctrl_if.sv
// Operand-fetch bus: issue request, register-file read port, writeback
// forwarding port and the operand handshake toward the ALU.
interface operand_fetch_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic [2:0]       src_a;
   logic [2:0]       src_b;
   logic             two_op;
   logic [2:0]       rf_addr;
   logic [15:0]      rf_data;
   logic             wb_en;
   logic [2:0]       wb_addr;
   logic [15:0]      wb_data;
   logic             op_ready;
   logic             busy;
   logic             op_valid;
   logic [15:0]      opa;
   logic [15:0]      opb;
   logic [CNT_W-1:0] op_cnt;

   modport master (
      output start, src_a, src_b, two_op, rf_data, wb_en, wb_addr, wb_data, op_ready,
      input  rf_addr, busy, op_valid, opa, opb, op_cnt
   );

   modport slave (
      input  start, src_a, src_b, two_op, rf_data, wb_en, wb_addr, wb_data, op_ready,
      output rf_addr, busy, op_valid, opa, opb, op_cnt
   );
endinterface

// File: rtl/operand_fetch_ctrl.sv
// Sequences one or two register-file reads per request over a shared read
// port, with r0 hardwiring and writeback forwarding, then holds the operands.
module operand_fetch_ctrl #(
   parameter int CNT_W = 8
) (
   input logic                 clk,
   input logic                 rst,
   operand_fetch_ctrl_if.slave bus
);
   localparam int DATA_W = 16;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD_A = 2'd1;
   localparam logic [1:0] RD_B = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]        state;
   logic [2:0]        src_a_q;
   logic [2:0]        src_b_q;
   logic              two_op_q;
   logic [DATA_W-1:0] opa_q;
   logic [DATA_W-1:0] opb_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        rd_addr;
   logic [DATA_W-1:0] rd_val;
   logic              accept;
   logic              handshake;

   // r0 reads as zero; otherwise a same-cycle writeback to the index wins.
   function automatic logic [DATA_W-1:0] fetch_value(
      input logic [2:0]        idx,
      input logic [DATA_W-1:0] rf,
      input logic              wen,
      input logic [2:0]        waddr,
      input logic [DATA_W-1:0] wdata
   );
      logic [DATA_W-1:0] v;
      if (idx == 3'd0)
         v = '0;
      else if (wen && (waddr == idx))
         v = wdata;
      else
         v = rf;
      return v;
   endfunction

   always_comb begin
      rd_addr = 3'd0;
      case (state)
         RD_A:    rd_addr = src_a_q;
         RD_B:    rd_addr = src_b_q;
         default: rd_addr = 3'd0;
      endcase
   end

   assign rd_val    = fetch_value(rd_addr, bus.rf_data, bus.wb_en, bus.wb_addr, bus.wb_data);
   assign handshake = (state == DONE) && bus.op_ready;
   assign accept    = bus.start && ((state == IDLE) || handshake);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         src_a_q  <= '0;
         src_b_q  <= '0;
         two_op_q <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         cnt_q    <= '0;
      end else begin
         if (accept) begin
            src_a_q  <= bus.src_a;
            src_b_q  <= bus.src_b;
            two_op_q <= bus.two_op;
         end
         if (handshake)
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         case (state)
            IDLE: if (accept) state <= RD_A;
            RD_A: begin
               opa_q <= rd_val;
               if (two_op_q) begin
                  state <= RD_B;
               end else begin
                  opb_q <= '0;
                  state <= DONE;
               end
            end
            RD_B: begin
               opb_q <= rd_val;
               state <= DONE;
            end
            DONE: begin
               if (handshake)
                  state <= accept ? RD_A : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rf_addr  = rd_addr;
   assign bus.busy     = (state != IDLE);
   assign bus.op_valid = (state == DONE);
   assign bus.opa      = opa_q;
   assign bus.opb      = opb_q;
   assign bus.op_cnt   = cnt_q;
endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Directed bench for operand_fetch_ctrl: a vector table of complete fetches
// plus hand-written sequences for backpressure, reset and counter wrap.
module tb_operand_fetch_ctrl;
   localparam int CNT_W = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic        rf_force;
   logic [15:0] rf [8];
   logic [7:0]  exp_cnt;

   operand_fetch_ctrl_if #(.CNT_W(CNT_W)) bus ();

   operand_fetch_ctrl #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      bus.rf_data = rf[bus.rf_addr];
      if (rf_force) bus.rf_data = 16'hFFFF;
   end

   typedef struct {
      logic [2:0]  a;
      logic [2:0]  b;
      logic        two;
      logic        force_ff;
      logic        wen;
      logic [2:0]  waddr;
      logic [15:0] wdata;
      logic [15:0] exp_a;
      logic [15:0] exp_b;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rf_addr"},  {29'd0, bus.rf_addr}, 32'd0);
      chk({tag, "_busy"},     {31'd0, bus.busy}, 32'd0);
      chk({tag, "_op_valid"}, {31'd0, bus.op_valid}, 32'd0);
      chk({tag, "_opa"},      {16'd0, bus.opa}, 32'd0);
      chk({tag, "_opb"},      {16'd0, bus.opb}, 32'd0);
      chk({tag, "_op_cnt"},   {24'd0, bus.op_cnt}, 32'd0);
   endtask

   // Fast single-operand handshake used for the wrap test.
   task automatic quick_op();
      bus.start = 1'b1; bus.src_a = 3'd1; bus.two_op = 1'b0;
      tick();
      bus.start = 1'b0;
      tick();
      bus.op_ready = 1'b1;
      tick();
      bus.op_ready = 1'b0;
      exp_cnt++;
   endtask

   initial begin
      checks = 0; errors = 0; exp_cnt = 8'd0;
      rf_force = 1'b0;
      rf[0] = 16'h9999; rf[1] = 16'h0101; rf[2] = 16'h0001; rf[3] = 16'h1234;
      rf[4] = 16'h4444; rf[5] = 16'hBEEF; rf[6] = 16'h6666; rf[7] = 16'h7777;
      bus.start = 1'b0; bus.src_a = 3'd0; bus.src_b = 3'd0; bus.two_op = 1'b0;
      bus.wb_en = 1'b0; bus.wb_addr = 3'd0; bus.wb_data = 16'h0; bus.op_ready = 1'b0;

      //           a     b     two   ff    wen   waddr wdata     exp_a     exp_b
      vecs[0] = '{3'd3, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h1234, 16'hBEEF};
      vecs[1] = '{3'd0, 3'd6, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
      vecs[2] = '{3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 16'hA5A5, 16'hA5A5, 16'h0000};
      vecs[3] = '{3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 16'hA5A5, 16'h0001, 16'h0000};
      vecs[4] = '{3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 16'h5555, 16'h0000, 16'h0000};
      vecs[5] = '{3'd7, 3'd4, 1'b1, 1'b0, 1'b1, 3'd4, 16'hCAFE, 16'h7777, 16'hCAFE};
      vecs[6] = '{3'd5, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'hBEEF, 16'hBEEF};
      vecs[7] = '{3'd6, 3'd1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h6666, 16'h0101};

      rst = 1'b1;
      tick();
      tick();
      chk_zero("reset");
      rst = 1'b0;
      tick();
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         rf_force = vecs[i].force_ff;
         bus.wb_en = vecs[i].wen; bus.wb_addr = vecs[i].waddr; bus.wb_data = vecs[i].wdata;
         bus.start = 1'b1; bus.src_a = vecs[i].a; bus.src_b = vecs[i].b; bus.two_op = vecs[i].two;
         tick();
         bus.start = 1'b0;
         bus.src_a = ~vecs[i].a; bus.src_b = ~vecs[i].b; bus.two_op = ~vecs[i].two;
         chk($sformatf("v%0d_rda_busy", i), {31'd0, bus.busy}, 32'd1);
         chk($sformatf("v%0d_rda_addr", i), {29'd0, bus.rf_addr}, {29'd0, vecs[i].a});
         chk($sformatf("v%0d_rda_valid", i), {31'd0, bus.op_valid}, 32'd0);
         tick();
         if (vecs[i].two) begin
            chk($sformatf("v%0d_rdb_addr", i), {29'd0, bus.rf_addr}, {29'd0, vecs[i].b});
            chk($sformatf("v%0d_rdb_valid", i), {31'd0, bus.op_valid}, 32'd0);
            tick();
         end
         chk($sformatf("v%0d_valid", i), {31'd0, bus.op_valid}, 32'd1);
         chk($sformatf("v%0d_done_addr", i), {29'd0, bus.rf_addr}, 32'd0);
         chk($sformatf("v%0d_opa", i), {16'd0, bus.opa}, {16'd0, vecs[i].exp_a});
         chk($sformatf("v%0d_opb", i), {16'd0, bus.opb}, {16'd0, vecs[i].exp_b});
         rf_force = 1'b0; bus.wb_en = 1'b0;
         bus.op_ready = 1'b1;
         tick();
         bus.op_ready = 1'b0;
         exp_cnt++;
         chk($sformatf("v%0d_idle_busy", i), {31'd0, bus.busy}, 32'd0);
         chk($sformatf("v%0d_cnt", i), {24'd0, bus.op_cnt}, {24'd0, exp_cnt});
      end

      // Operands persist in IDLE; op_ready without op_valid does nothing.
      bus.op_ready = 1'b1;
      tick();
      bus.op_ready = 1'b0;
      chk("idle_opa_hold", {16'd0, bus.opa}, 32'h6666);
      chk("idle_opb_hold", {16'd0, bus.opb}, 32'h0101);
      chk("idle_ready_cnt", {24'd0, bus.op_cnt}, {24'd0, exp_cnt});

      // Backpressure, ignored starts, then back-to-back acceptance.
      bus.start = 1'b1; bus.src_a = 3'd3; bus.src_b = 3'd5; bus.two_op = 1'b1;
      tick();
      bus.src_a = 3'd7; bus.src_b = 3'd4; bus.two_op = 1'b0;
      tick();
      chk("bp_rdb_addr", {29'd0, bus.rf_addr}, 32'd5);
      bus.start = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         bus.start = (c == 2);
         chk($sformatf("bp_valid_c%0d", c), {31'd0, bus.op_valid}, 32'd1);
         chk($sformatf("bp_opa_c%0d", c), {16'd0, bus.opa}, 32'h1234);
         chk($sformatf("bp_opb_c%0d", c), {16'd0, bus.opb}, 32'hBEEF);
         tick();
      end
      chk("bp_after_valid", {31'd0, bus.op_valid}, 32'd1);
      chk("bp_after_opa", {16'd0, bus.opa}, 32'h1234);
      bus.start = 1'b1; bus.src_a = 3'd7; bus.two_op = 1'b0; bus.op_ready = 1'b1;
      tick();
      bus.start = 1'b0; bus.op_ready = 1'b0;
      exp_cnt++;
      chk("b2b_cnt", {24'd0, bus.op_cnt}, {24'd0, exp_cnt});
      chk("b2b_rda_addr", {29'd0, bus.rf_addr}, 32'd7);
      chk("b2b_valid_low", {31'd0, bus.op_valid}, 32'd0);
      tick();
      chk("b2b_valid", {31'd0, bus.op_valid}, 32'd1);
      chk("b2b_opa", {16'd0, bus.opa}, 32'h7777);
      chk("b2b_opb", {16'd0, bus.opb}, 32'h0000);
      bus.op_ready = 1'b1;
      tick();
      bus.op_ready = 1'b0;

      // Asynchronous reset while in RD_B.
      bus.start = 1'b1; bus.src_a = 3'd3; bus.src_b = 3'd5; bus.two_op = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("rst_pre_rdb_addr", {29'd0, bus.rf_addr}, 32'd5);
      #2;
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      #2;
      rst = 1'b0;
      tick();
      chk_zero("post_rst");
      exp_cnt = 8'd0;

      bus.start = 1'b1; bus.src_a = 3'd2; bus.two_op = 1'b0;
      tick();
      bus.start = 1'b0;
      tick();
      chk("post_rst_valid", {31'd0, bus.op_valid}, 32'd1);
      chk("post_rst_opa", {16'd0, bus.opa}, 32'h0001);
      bus.op_ready = 1'b1;
      tick();
      bus.op_ready = 1'b0;
      exp_cnt++;
      chk("post_rst_cnt", {24'd0, bus.op_cnt}, {24'd0, exp_cnt});

      // Counter wrap: 256 handshakes since reset bring op_cnt back to zero.
      while (exp_cnt != 8'd255) quick_op();
      chk("cnt_ff", {24'd0, bus.op_cnt}, 32'hFF);
      quick_op();
      chk("cnt_wrap", {24'd0, bus.op_cnt}, 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
